// File: rtl/ws2812b_frame_sequencer_if.sv
// ws2812b_frame_sequencer_if: pixel valid/ready handshake toward the WS2812B serializer.
interface ws2812b_frame_sequencer_if;
    logic [23:0] px_data;
    logic        px_valid;
    logic        px_latch;
    logic        px_ready;
    modport master (output px_data, px_valid, px_latch, input px_ready);
    modport slave  (input px_data, px_valid, px_latch, output px_ready);
endinterface

// File: rtl/ws2812b_frame_sequencer.sv
// ws2812b_frame_sequencer: fetches, brightness-scales and issues a frame of pixels, optionally auto-repeating.
module ws2812b_frame_sequencer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             buf_we,
    input  logic [AW-1:0]                    buf_addr,
    input  logic [23:0]                      buf_wdata,
    input  logic                             start,
    input  logic [AW-1:0]                    len,
    input  logic [7:0]                       brightness,
    input  logic [19:0]                      refresh_period,
    input  logic                             stop,
    ws2812b_frame_sequencer_if.master        px,
    output logic                             busy,
    output logic                             frame_done
);
    typedef enum logic [2:0] {IDLE, FETCH, SCALE, ISSUE, GAP} state_t;
    state_t        state, state_nxt;
    logic [23:0]   mem [DEPTH];
    logic [23:0]   rd_data;
    logic [AW-1:0] rptr, len_q;
    logic [7:0]    bright_q;
    logic [19:0]   period_q, gap_cnt;
    logic          armed, stop_pending;

    function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
        logic [16:0] p;
        p = {9'd0, c} * {8'd0, {1'b0, b} + 9'd1};
        return p[15:8];
    endfunction

    always_ff @(posedge clk) state <= reset ? IDLE : state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? FETCH : IDLE;
            FETCH:   state_nxt = SCALE;
            SCALE:   state_nxt = ISSUE;
            ISSUE:   state_nxt = !px.px_valid ? ISSUE :
                                 !px.px_latch ? FETCH :
                                 (period_q != '0 && !stop_pending && !stop) ? GAP : IDLE;
            GAP:     state_nxt = stop ? IDLE : (gap_cnt == '0) ? FETCH : GAP;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        px.px_valid = (state == ISSUE) && px.px_ready && armed;
        px.px_latch = px.px_valid && (rptr == len_q);
        busy        = state != IDLE;
    end

    // No reset on the buffer; a write at rptr during FETCH lands after the read.
    always_ff @(posedge clk) if (buf_we) mem[buf_addr] <= buf_wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            armed        <= 1'b1;
            stop_pending <= 1'b0;
            frame_done   <= 1'b0;
            px.px_data   <= '0;
            rd_data      <= '0;
            rptr         <= '0;
            len_q        <= '0;
            bright_q     <= '0;
            period_q     <= '0;
            gap_cnt      <= '0;
        end else begin
            frame_done <= px.px_latch;
            if (!px.px_ready) armed <= 1'b1;
            else if (px.px_valid) armed <= 1'b0;
            if (stop && state != IDLE && state != GAP) stop_pending <= 1'b1;
            if (state == IDLE && start) begin
                len_q        <= len;
                bright_q     <= brightness;
                period_q     <= refresh_period;
                rptr         <= '0;
                stop_pending <= 1'b0;
            end
            if (state == FETCH) rd_data <= mem[rptr];
            if (state == SCALE)
                px.px_data <= {scale(rd_data[23:16], bright_q), scale(rd_data[15:8], bright_q),
                               scale(rd_data[7:0], bright_q)};
            if (px.px_valid && !px.px_latch) rptr <= rptr + AW'(1);
            if (px.px_latch) gap_cnt <= period_q;
            else if (state == GAP) gap_cnt <= gap_cnt - 20'd1;
            // Each repeat picks up the current brightness setting.
            if (state == GAP && gap_cnt == '0) begin
                bright_q <= brightness;
                rptr     <= '0;
            end
        end
    end
endmodule
